operand_fetch: RTL and testbench

//  Register-read stage directly upstream of the execute stage. Holds the 2^W_RD x W_OPR register file.

---
 rtl/operand_fetch_pkg.sv | 37 +++
 rtl/operand_fetch_if.sv | 46 ++++
 rtl/operand_fetch_regfile.sv | 27 ++
 rtl/operand_fetch.sv | 91 +++++++++
 tb/tb_operand_fetch.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths, d_info bit positions, halt-FSM states and source-match helpers
// for the operand-fetch stage.
package operand_fetch_pkg;

    localparam int ADDR   = 16;
    localparam int W_IMM  = 16;
    localparam int W_OPR  = 32;
    localparam int W_RD   = 5;
    localparam int D_INFO = 16;
    localparam int WRSV   = 0;
    localparam int HLTF   = 1;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    function automatic logic src_hit(
        input logic            used,
        input logic [W_RD-1:0] rs,
        input logic [W_RD-1:0] rd
    );
        return used && (rs == rd);
    endfunction

    // Write-back data wins over the stored value for a same-cycle read.
    function automatic logic [W_OPR-1:0] fwd(
        input logic             we,
        input logic [W_RD-1:0]  wr,
        input logic [W_RD-1:0]  rs,
        input logic [W_OPR-1:0] wdata,
        input logic [W_OPR-1:0] rfdata
    );
        return (we && (wr == rs)) ? wdata : rfdata;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side, execute-side and write-back signals of the operand-fetch stage.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic              v_i;
    logic [ADDR-1:0]   pc_i;
    logic [W_IMM-1:0]  imm_i;
    logic [W_RD-1:0]   rs0_i;
    logic [W_RD-1:0]   rs1_i;
    logic              use0_i;
    logic              use1_i;
    logic [W_RD-1:0]   rd_i;
    logic [D_INFO-1:0] d_info_i;
    logic              stall_o;

    logic              v_o;
    logic [ADDR-1:0]   pc_o;
    logic [W_IMM-1:0]  imm_o;
    logic [W_OPR-1:0]  opr0_o;
    logic [W_OPR-1:0]  opr1_o;
    logic [D_INFO-1:0] d_info_o;
    logic [W_RD-1:0]   wb_r_o;
    logic              stall_i;

    logic              wb_i;
    logic [W_RD-1:0]   wb_r_i;
    logic [W_OPR-1:0]  wb_data_i;
    logic              halted_o;

    modport slave (
        input  v_i, pc_i, imm_i, rs0_i, rs1_i, use0_i, use1_i, rd_i, d_info_i,
        output stall_o,
        output v_o, pc_o, imm_o, opr0_o, opr1_o, d_info_o, wb_r_o,
        input  stall_i, wb_i, wb_r_i, wb_data_i,
        output halted_o
    );

    modport master (
        output v_i, pc_i, imm_i, rs0_i, rs1_i, use0_i, use1_i, rd_i, d_info_i,
        input  stall_o,
        input  v_o, pc_o, imm_o, opr0_o, opr1_o, d_info_o, wb_r_o,
        output stall_i, wb_i, wb_r_i, wb_data_i,
        input  halted_o
    );

endinterface

// File: rtl/operand_fetch_regfile.sv
// 2^W_RD x W_OPR register file: two asynchronous read ports, one synchronous
// write port, contents not reset.
module operand_fetch_regfile
    import operand_fetch_pkg::*;
(
    input  logic             clk,
    input  logic             i_we,
    input  logic [W_RD-1:0]  i_waddr,
    input  logic [W_OPR-1:0] i_wdata,
    input  logic [W_RD-1:0]  i_raddr0,
    input  logic [W_RD-1:0]  i_raddr1,
    output logic [W_OPR-1:0] o_rdata0,
    output logic [W_OPR-1:0] o_rdata1
);

    logic [W_OPR-1:0] r_mem [0:(1<<W_RD)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: bypassed operand read, RAW hazard bubble, registered
// bundle to execute, and a halt latch that idles the stage until reset.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);

    logic              w_adv;
    logic              w_pend;
    logic              w_haz;
    logic              w_halted;
    logic              w_take;
    logic [W_OPR-1:0]  w_rf0;
    logic [W_OPR-1:0]  w_rf1;
    logic [W_OPR-1:0]  w_opr0;
    logic [W_OPR-1:0]  w_opr1;

    state_t            r_state;
    logic              r_v;
    logic [ADDR-1:0]   r_pc;
    logic [W_IMM-1:0]  r_imm;
    logic [W_OPR-1:0]  r_opr0;
    logic [W_OPR-1:0]  r_opr1;
    logic [D_INFO-1:0] r_d_info;
    logic [W_RD-1:0]   r_wb_r;

    operand_fetch_regfile u_regfile (
        .clk      (clk),
        .i_we     (bus.wb_i),
        .i_waddr  (bus.wb_r_i),
        .i_wdata  (bus.wb_data_i),
        .i_raddr0 (bus.rs0_i),
        .i_raddr1 (bus.rs1_i),
        .o_rdata0 (w_rf0),
        .o_rdata1 (w_rf1)
    );

    assign w_halted = (r_state == S_HALT);
    assign w_adv    = ~(bus.stall_i & r_v);
    // The bundle in execute only has its result on wb_data_i one cycle later.
    assign w_pend   = r_v & r_d_info[WRSV];
    assign w_haz    = bus.v_i & w_pend &
                      (src_hit(bus.use0_i, bus.rs0_i, r_wb_r) |
                       src_hit(bus.use1_i, bus.rs1_i, r_wb_r));
    assign w_take   = bus.v_i & ~w_haz & ~w_halted;

    assign w_opr0 = fwd(bus.wb_i, bus.wb_r_i, bus.rs0_i, bus.wb_data_i, w_rf0);
    assign w_opr1 = fwd(bus.wb_i, bus.wb_r_i, bus.rs1_i, bus.wb_data_i, w_rf1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_v      <= 1'b0;
            r_pc     <= '0;
            r_imm    <= '0;
            r_opr0   <= '0;
            r_opr1   <= '0;
            r_d_info <= '0;
            r_wb_r   <= '0;
        end else begin
            if (w_adv) begin
                r_v      <= w_take;
                r_pc     <= bus.pc_i;
                r_imm    <= bus.imm_i;
                r_opr0   <= w_opr0;
                r_opr1   <= w_opr1;
                r_d_info <= bus.d_info_i;
                r_wb_r   <= bus.rd_i;
            end
            case (r_state)
                S_RUN:   if (w_adv && w_take && bus.d_info_i[HLTF]) r_state <= S_HALT;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign bus.stall_o  = bus.v_i & ~w_halted & (~w_adv | w_haz);
    assign bus.v_o      = r_v;
    assign bus.pc_o     = r_pc;
    assign bus.imm_o    = r_imm;
    assign bus.opr0_o   = r_opr0;
    assign bus.opr1_o   = r_opr1;
    assign bus.d_info_o = r_d_info;
    assign bus.wb_r_o   = r_wb_r;
    assign bus.halted_o = w_halted;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch: each row is one cycle of
// inputs plus the stall_o expected before the edge and outputs after it.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_if bus();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst, v;
        logic [15:0] pc;
        logic [4:0]  rs0, rs1;
        logic        u0, u1;
        logic [4:0]  rd;
        logic [15:0] di;
        logic        si, wb;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic        e_stall, e_v, e_halt, ck;
        logic [15:0] e_pc;
        logic [4:0]  e_rd;
        logic [15:0] e_di;
        logic        ck0;
        logic [31:0] e_o0;
        logic        ck1;
        logic [31:0] e_o1;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   row   = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        reset          = t.rst;
        bus.v_i        = t.v;
        bus.pc_i       = t.pc;
        bus.imm_i      = t.pc ^ 16'hA5A5;
        bus.rs0_i      = t.rs0;
        bus.rs1_i      = t.rs1;
        bus.use0_i     = t.u0;
        bus.use1_i     = t.u1;
        bus.rd_i       = t.rd;
        bus.d_info_i   = t.di;
        bus.stall_i    = t.si;
        bus.wb_i       = t.wb;
        bus.wb_r_i     = t.wbr;
        bus.wb_data_i  = t.wbd;
    endtask

    task automatic run_row(input vec_t t);
        logic [15:0] e_imm;
        drive(t);
        #2;
        chk("stall_o", 32'(bus.stall_o), 32'(t.e_stall));
        @(posedge clk);
        #1;
        chk("v_o", 32'(bus.v_o), 32'(t.e_v));
        chk("halted_o", 32'(bus.halted_o), 32'(t.e_halt));
        if (t.ck) begin
            e_imm = t.rst ? 16'h0000 : (t.e_pc ^ 16'hA5A5);
            chk("pc_o", 32'(bus.pc_o), 32'(t.e_pc));
            chk("imm_o", 32'(bus.imm_o), 32'(e_imm));
            chk("wb_r_o", 32'(bus.wb_r_o), 32'(t.e_rd));
            chk("d_info_o", 32'(bus.d_info_o), 32'(t.e_di));
        end
        if (t.ck0) chk("opr0_o", bus.opr0_o, t.e_o0);
        if (t.ck1) chk("opr1_o", bus.opr1_o, t.e_o1);
    endtask

    initial begin
        //                 rst v  pc      rs0 rs1 u0 u1 rd  di     si wb wbr wbd            stl ev eh ck e_pc    erd edi    ck0 e_o0          ck1 e_o1
        // bypass, including rs0 == rs1
        vecs.push_back(vec_t'{0, 1, 16'h0010, 3, 3, 1, 1, 1, 16'h0, 0, 1, 3, 32'hDEADBEEF, 0, 1, 0, 1, 16'h0010, 1, 16'h0, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF});
        // stored read of r3; this bundle writes r5
        vecs.push_back(vec_t'{0, 1, 16'h0011, 3, 3, 1, 0, 5, 16'h1, 0, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0011, 5, 16'h1, 1, 32'hDEADBEEF, 0, 32'h0});
        // RAW on r5 via rs1: stall + bubble, then bypass of execute's result
        vecs.push_back(vec_t'{0, 1, 16'h0012, 0, 5, 0, 1, 6, 16'h0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 16'h0,    0, 16'h0, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0012, 0, 5, 0, 1, 6, 16'h0, 0, 1, 5, 32'h12345678, 0, 1, 0, 1, 16'h0012, 6, 16'h0, 0, 32'h0,        1, 32'h12345678});
        // no false hazard: rd=5 without WRSV, then WRSV with rs0 unused
        vecs.push_back(vec_t'{0, 1, 16'h0020, 0, 0, 0, 0, 5, 16'h0, 0, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0020, 5, 16'h0, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0021, 5, 0, 1, 0, 5, 16'h1, 0, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0021, 5, 16'h1, 1, 32'h12345678, 0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0022, 5, 7, 0, 1, 2, 16'h0, 0, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0022, 2, 16'h0, 0, 32'h0,        0, 32'h0});
        // downstream stall for 3 cycles, then release
        vecs.push_back(vec_t'{0, 1, 16'h0030, 0, 0, 0, 0, 8, 16'h0, 0, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0030, 8, 16'h0, 0, 32'h0,        0, 32'h0});
        for (int k = 0; k < 3; k++)
            vecs.push_back(vec_t'{0, 1, 16'h0031, 0, 0, 0, 0, 9, 16'h4, 1, 0, 0, 32'h0,    1, 1, 0, 1, 16'h0030, 8, 16'h0, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0031, 0, 0, 0, 0, 9, 16'h4, 0, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0031, 9, 16'h4, 0, 32'h0,        0, 32'h0});
        // stall_i with v_o=0 still accepts
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 16'h0,    0, 16'h0, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0040, 0, 0, 0, 0, 3, 16'h0, 1, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0040, 3, 16'h0, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 16'h0,    0, 16'h0, 0, 32'h0,        0, 32'h0});
        // halt: issued once, stage idles, stall_o gated even under stall_i, wb still writes
        vecs.push_back(vec_t'{0, 1, 16'h0050, 0, 0, 0, 0, 1, 16'h2, 0, 0, 0, 32'h0,        0, 1, 1, 1, 16'h0050, 1, 16'h2, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0051, 0, 0, 0, 0, 2, 16'h0, 1, 1, 9, 32'hCAFEF00D, 0, 1, 1, 1, 16'h0050, 1, 16'h2, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0052, 0, 0, 0, 0, 2, 16'h0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 16'h0,    0, 16'h0, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0053, 0, 0, 0, 0, 2, 16'h0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 16'h0,    0, 16'h0, 0, 32'h0,        0, 32'h0});
        // reset returns to RUN; register file survives reset
        vecs.push_back(vec_t'{1, 1, 16'h0054, 0, 0, 0, 0, 2, 16'h0, 0, 0, 0, 32'h0,        0, 0, 0, 1, 16'h0,    0, 16'h0, 0, 32'h0,        0, 32'h0});
        vecs.push_back(vec_t'{0, 1, 16'h0060, 9, 3, 1, 1, 4, 16'h8, 0, 0, 0, 32'h0,        0, 1, 0, 1, 16'h0060, 4, 16'h8, 1, 32'hCAFEF00D, 1, 32'hDEADBEEF});
        // reset while execute stalls drops the held bundle
        vecs.push_back(vec_t'{1, 1, 16'h0061, 0, 0, 0, 0, 7, 16'h3, 1, 0, 0, 32'h0,        1, 0, 0, 1, 16'h0,    0, 16'h0, 0, 32'h0,        0, 32'h0});

        drive(vec_t'{1, 1, 16'h0010, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 32'h0,
                     0, 0, 0, 0, 16'h0, 0, 16'h0, 0, 32'h0, 0, 32'h0});
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("reset v_o", 32'(bus.v_o), 32'd0);
            chk("reset halted_o", 32'(bus.halted_o), 32'd0);
            chk("reset pc_o", 32'(bus.pc_o), 32'd0);
            chk("reset stall_o", 32'(bus.stall_o), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            row = i;
            run_row(vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
